// File: rtl/icache_mem_arbiter_if.sv
// Purpose : bundles the I-side refill port, the D-side port and the memory port of the arbiter.
// Latency : none (wires only).
// Backpressure: requests are held until the matching ready pulse; memory request held until mem_ready_i.
// Modports: slave = arbiter view (takes requests, drives memory); master = requester/memory view.
interface icache_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  // I-side (read-only refill)
  logic [ADDR_WIDTH-1:0] i_addr_i;
  logic                  i_valid_i;
  logic [31:0]           i_rdata_o;
  logic                  i_ready_o;
  // D-side (read/write)
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [31:0]           d_wdata_i;
  logic [3:0]            d_wstrb_i;
  logic                  d_valid_i;
  logic [31:0]           d_rdata_o;
  logic                  d_ready_o;
  // shared memory port
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_wdata_o;
  logic [3:0]            mem_wstrb_o;
  logic                  mem_valid_o;
  logic [31:0]           mem_rdata_i;
  logic                  mem_ready_i;
  // {D,I} owner
  logic [1:0]            grant_o;

  modport slave (
    input  i_addr_i, i_valid_i,
    input  d_addr_i, d_wdata_i, d_wstrb_i, d_valid_i,
    input  mem_rdata_i, mem_ready_i,
    output i_rdata_o, i_ready_o,
    output d_rdata_o, d_ready_o,
    output mem_addr_o, mem_wdata_o, mem_wstrb_o, mem_valid_o,
    output grant_o
  );

  modport master (
    output i_addr_i, i_valid_i,
    output d_addr_i, d_wdata_i, d_wstrb_i, d_valid_i,
    output mem_rdata_i, mem_ready_i,
    input  i_rdata_o, i_ready_o,
    input  d_rdata_o, d_ready_o,
    input  mem_addr_o, mem_wdata_o, mem_wstrb_o, mem_valid_o,
    input  grant_o
  );
endinterface

// File: rtl/icache_mem_arbiter.sv
// Purpose : shares one memory port between the I-side refill and D-side ports, one transaction at a time.
// Latency : mem_valid_o rises 1 cycle after a request is seen in IDLE; ready/rdata follow mem_ready_i combinationally.
// Backpressure: requesters hold valid until their ready pulse; the memory request is held until mem_ready_i.
// Ports: clk; resetn (async, active-low); bus (slave modport) carrying i_*, d_*, mem_* and grant_o.
module icache_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int ARB_MODE     = 1,   // 0 = round-robin, 1 = D priority with I starvation guard
  parameter int STARVE_LIMIT = 8    // 1..255
) (
  input  logic               clk,
  input  logic               resetn,
  icache_mem_arbiter_if.slave bus
);

  // Grant states are encoded so the state register is the {D,I} grant vector itself:
  // grant_o and mem_valid_o come straight from flops.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [31:0]           wdata_q, wdata_nxt;
  logic [3:0]            wstrb_q, wstrb_nxt;
  logic [7:0]            starve_cnt, starve_nxt;
  logic                  rr_last_d, rr_nxt;     // 1: D won the most recent grant
  logic                  pick_i, pick_d;

  // Winner selection from the live request lines; only acted upon in IDLE.
  always_comb begin
    pick_i = bus.i_valid_i;
    pick_d = bus.d_valid_i;
    if (bus.i_valid_i && bus.d_valid_i) begin
      if (ARB_MODE == 0) begin
        pick_i = rr_last_d;
      end else begin
        pick_i = (starve_cnt >= 8'(STARVE_LIMIT));
      end
      pick_d = !pick_i;
    end
  end

  // Next state, field capture, round-robin pointer and starvation counter.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    wstrb_nxt = wstrb_q;
    rr_nxt    = rr_last_d;
    case (state)
      IDLE: begin
        if (pick_i) begin
          state_nxt = GNT_I;
          addr_nxt  = bus.i_addr_i;
          wdata_nxt = '0;
          wstrb_nxt = '0;
          rr_nxt    = 1'b0;
        end else if (pick_d) begin
          state_nxt = GNT_D;
          addr_nxt  = bus.d_addr_i;
          wdata_nxt = bus.d_wdata_i;
          wstrb_nxt = bus.d_wstrb_i;
          rr_nxt    = 1'b1;
        end
      end
      GNT_I, GNT_D: begin
        if (bus.mem_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Counts cycles the I-side waits while someone else (or nobody) owns the port.
    starve_nxt = starve_cnt;
    if (ARB_MODE == 0 || !bus.i_valid_i || state == GNT_I || (state == IDLE && pick_i)) begin
      starve_nxt = '0;
    end else if (starve_cnt != 8'hFF) begin
      starve_nxt = starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      starve_cnt <= '0;
      rr_last_d  <= 1'b1;   // I wins the first round-robin tie
    end else begin
      state      <= state_nxt;
      addr_q     <= addr_nxt;
      wdata_q    <= wdata_nxt;
      wstrb_q    <= wstrb_nxt;
      starve_cnt <= starve_nxt;
      rr_last_d  <= rr_nxt;
    end
  end

  assign bus.grant_o     = state;
  assign bus.mem_valid_o = (state != IDLE);
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_wstrb_o = wstrb_q;

  // Completion is routed to the owner only; mem_ready_i while IDLE goes nowhere.
  assign bus.i_ready_o = (state == GNT_I) && bus.mem_ready_i;
  assign bus.d_ready_o = (state == GNT_D) && bus.mem_ready_i;
  assign bus.i_rdata_o = bus.i_ready_o ? bus.mem_rdata_i : 32'h0;
  assign bus.d_rdata_o = bus.d_ready_o ? bus.mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_icache_mem_arbiter.sv
// Bench for icache_mem_arbiter: two instances (round-robin and D-priority), random requesters and
// memory, a transaction-level reference model per instance, plus directed scenarios.
module tb_icache_mem_arbiter;

  localparam int LIMIT = 8;

  logic clk;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int b, input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL bus%0d %s: observed=%0h expected=%0h", b, tag, obs, exp);
    end
  endtask

  // g[0]: ARB_MODE=0 (round-robin), g[1]: ARB_MODE=1 (D priority + starvation guard)
  for (genvar b = 0; b < 2; b++) begin : g
    icache_mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

    icache_mem_arbiter #(
      .ADDR_WIDTH  (32),
      .ARB_MODE    (b),
      .STARVE_LIMIT(LIMIT)
    ) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus.slave)
    );

    // knobs written only by the stimulus block
    bit          i_auto, d_auto, use_cfg, mem_en, fix_en;
    int          mem_lat;
    int          inj_req;
    logic [31:0] i_addr_cfg, d_addr_cfg, d_wdata_cfg, fix_rdata;
    logic [3:0]  d_wstrb_cfg;

    int mcnt;
    int inj_done;
    bit i_done, d_done;

    // memory controller: pulses mem_ready_i mem_lat cycles after it sees mem_valid_o
    always @(posedge clk) begin
      #1;
      if (!resetn) begin
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = '0;
        mcnt = 0;
      end else if (bus.mem_ready_i) begin
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = '0;
      end else if (inj_req != inj_done) begin
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = $urandom;
        inj_done = inj_req;
      end else if (mem_en && bus.mem_valid_o) begin
        if (mcnt >= mem_lat) begin
          bus.mem_ready_i = 1'b1;
          bus.mem_rdata_i = fix_en ? fix_rdata : $urandom;
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end else begin
        mcnt = 0;
      end
    end

    always @(negedge clk) begin
      i_done = bus.i_ready_o;
      d_done = bus.d_ready_o;
    end

    // requesters: hold valid until ready, re-request at once while auto; scramble fields once granted
    always @(posedge clk) begin
      #1;
      if (!resetn) begin
        bus.i_valid_i = 1'b0; bus.i_addr_i = '0;
        bus.d_valid_i = 1'b0; bus.d_addr_i = '0; bus.d_wdata_i = '0; bus.d_wstrb_i = '0;
      end else begin
        if (!bus.i_valid_i || i_done) begin
          bus.i_valid_i = i_auto;
          bus.i_addr_i  = use_cfg ? i_addr_cfg : $urandom;
        end else if (bus.grant_o[0]) begin
          bus.i_addr_i = $urandom;
        end
        if (!bus.d_valid_i || d_done) begin
          bus.d_valid_i = d_auto;
          bus.d_addr_i  = use_cfg ? d_addr_cfg : $urandom;
          bus.d_wdata_i = use_cfg ? d_wdata_cfg : $urandom;
          bus.d_wstrb_i = use_cfg ? d_wstrb_cfg : 4'($urandom);
        end else if (bus.grant_o[1]) begin
          bus.d_addr_i  = $urandom;
          bus.d_wdata_i = $urandom;
          bus.d_wstrb_i = 4'($urandom);
        end
      end
    end

    // reference model: owner (0 none, 1 I, 2 D), cycles I has waited, last winner
    int          m_owner, m_wait, m_rr, m_win;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic        e_ir, e_dr;
    int          gseq[$];

    always @(negedge clk) begin
      if (!resetn) begin
        m_owner = 0;
        m_wait  = 0;
        m_rr    = 2;
      end else begin
        e_ir = (m_owner == 1) && bus.mem_ready_i;
        e_dr = (m_owner == 2) && bus.mem_ready_i;
        chk(b, "grant", bus.grant_o, (m_owner == 2) ? 2'b10 : (m_owner == 1) ? 2'b01 : 2'b00);
        chk(b, "mem_valid", bus.mem_valid_o, m_owner != 0);
        if (m_owner != 0) begin
          chk(b, "mem_addr", bus.mem_addr_o, e_addr);
          chk(b, "mem_wdata", bus.mem_wdata_o, e_wdata);
          chk(b, "mem_wstrb", bus.mem_wstrb_o, e_wstrb);
        end
        chk(b, "i_ready", bus.i_ready_o, e_ir);
        chk(b, "d_ready", bus.d_ready_o, e_dr);
        chk(b, "i_rdata", bus.i_rdata_o, e_ir ? bus.mem_rdata_i : 32'h0);
        chk(b, "d_rdata", bus.d_rdata_o, e_dr ? bus.mem_rdata_i : 32'h0);

        m_win = 0;
        if (m_owner == 0) begin
          if (bus.i_valid_i && bus.d_valid_i) begin
            if (b == 0) m_win = (m_rr == 2) ? 1 : 2;
            else        m_win = (m_wait >= LIMIT) ? 1 : 2;
          end else if (bus.i_valid_i) m_win = 1;
          else if (bus.d_valid_i)     m_win = 2;
        end

        if (!bus.i_valid_i || m_owner == 1 || m_win == 1) m_wait = 0;
        else if (m_wait < 255) m_wait++;

        if (m_owner != 0) begin
          if (bus.mem_ready_i) m_owner = 0;
        end else if (m_win != 0) begin
          m_owner = m_win;
          m_rr    = m_win;
          gseq.push_back(m_win);
          e_addr  = (m_win == 1) ? bus.i_addr_i : bus.d_addr_i;
          e_wdata = (m_win == 1) ? 32'h0 : bus.d_wdata_i;
          e_wstrb = (m_win == 1) ? 4'h0 : bus.d_wstrb_i;
        end
      end
    end
  end

  initial begin
    bit got;
    int cnt;
    int nd;
    int k;

    resetn = 1'b0;
    g[0].mem_en = 1'b1;
    g[1].mem_en = 1'b1;
    repeat (3) @(negedge clk);

    // reset values
    chk(1, "rst_mem_valid", g[1].bus.mem_valid_o, 1'b0);
    chk(1, "rst_grant", g[1].bus.grant_o, 2'b00);
    chk(1, "rst_mem_addr", g[1].bus.mem_addr_o, 32'h0);
    chk(1, "rst_mem_wdata", g[1].bus.mem_wdata_o, 32'h0);
    chk(1, "rst_mem_wstrb", g[1].bus.mem_wstrb_o, 4'h0);
    chk(1, "rst_ready", {g[1].bus.i_ready_o, g[1].bus.d_ready_o}, 2'b00);
    chk(0, "rst_mem_valid", g[0].bus.mem_valid_o, 1'b0);
    chk(0, "rst_grant", g[0].bus.grant_o, 2'b00);

    @(posedge clk); #3 resetn = 1'b1;
    repeat (2) @(negedge clk);

    // I-only read on the D-priority instance, memory answers 2 cycles late
    g[1].use_cfg = 1'b1; g[1].i_addr_cfg = 32'h8000_0010;
    g[1].fix_en = 1'b1;  g[1].fix_rdata = 32'hDEAD_BEEF;
    g[1].mem_lat = 2;    g[1].i_auto = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (g[1].bus.i_ready_o) begin
        got = 1'b1;
        g[1].i_auto = 1'b0;
        chk(1, "t1_rdata", g[1].bus.i_rdata_o, 32'hDEAD_BEEF);
        chk(1, "t1_mem_addr", g[1].bus.mem_addr_o, 32'h8000_0010);
        chk(1, "t1_mem_wstrb", g[1].bus.mem_wstrb_o, 4'h0);
        chk(1, "t1_mem_wdata", g[1].bus.mem_wdata_o, 32'h0);
        chk(1, "t1_grant_on", g[1].bus.grant_o, 2'b01);
      end
    end
    chk(1, "t1_completed", got, 1'b1);
    @(negedge clk);
    chk(1, "t1_grant_off", g[1].bus.grant_o, 2'b00);
    g[1].fix_en = 1'b0;
    repeat (3) @(negedge clk);

    // D write; fields scrambled after grant must not reach memory
    g[1].d_addr_cfg = 32'h0000_1000; g[1].d_wdata_cfg = 32'h1234_5678; g[1].d_wstrb_cfg = 4'b0011;
    g[1].mem_lat = 3; g[1].d_auto = 1'b1;
    got = 1'b0; cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (g[1].bus.grant_o == 2'b10) begin
        if (!got) begin
          chk(1, "t2_wdata", g[1].bus.mem_wdata_o, 32'h1234_5678);
          chk(1, "t2_wstrb", g[1].bus.mem_wstrb_o, 4'b0011);
        end
        got = 1'b1;
        chk(1, "t2_addr_hold", g[1].bus.mem_addr_o, 32'h0000_1000);
      end
      if (g[1].bus.d_ready_o) begin
        cnt++;
        g[1].d_auto = 1'b0;
      end
    end
    chk(1, "t2_granted", got, 1'b1);
    chk(1, "t2_ready_pulses", cnt, 1);
    g[1].use_cfg = 1'b0;

    // starvation guard: both always requesting, 0-wait memory
    g[1].mem_lat = 0;
    g[1].gseq.delete();
    g[1].i_auto = 1'b1; g[1].d_auto = 1'b1;
    for (int n = 0; n < 400 && g[1].gseq.size() < 25; n++) @(negedge clk);
    g[1].i_auto = 1'b0; g[1].d_auto = 1'b0;
    chk(1, "t3_enough_grants", g[1].gseq.size() >= 25, 1'b1);
    // each D transaction costs I two waiting cycles, so I wins after ceil(LIMIT/2) D grants
    nd = (LIMIT + 1) / 2;
    for (int n = 0; n < 25 && n < g[1].gseq.size(); n++) begin
      k = g[1].gseq[n];
      chk(1, $sformatf("t3_grant%0d", n), k, ((n % (nd + 1)) == nd) ? 1 : 2);
    end
    repeat (10) @(negedge clk);

    // round-robin alternation, starting with I after reset
    g[0].mem_lat = 1;
    g[0].gseq.delete();
    g[0].i_auto = 1'b1; g[0].d_auto = 1'b1;
    for (int n = 0; n < 400 && g[0].gseq.size() < 12; n++) @(negedge clk);
    g[0].i_auto = 1'b0; g[0].d_auto = 1'b0;
    chk(0, "t4_enough_grants", g[0].gseq.size() >= 12, 1'b1);
    for (int n = 0; n < 12 && n < g[0].gseq.size(); n++) begin
      k = g[0].gseq[n];
      chk(0, $sformatf("t4_grant%0d", n), k, (n % 2 == 0) ? 1 : 2);
    end
    repeat (10) @(negedge clk);

    // random traffic on both instances, checked by the models
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      if (n % 7 == 0) begin
        g[0].i_auto = ($urandom_range(0, 3) != 0); g[0].d_auto = ($urandom_range(0, 3) != 0);
        g[1].i_auto = ($urandom_range(0, 3) != 0); g[1].d_auto = ($urandom_range(0, 3) != 0);
        g[0].mem_lat = $urandom_range(0, 3);
        g[1].mem_lat = $urandom_range(0, 3);
      end
    end
    g[0].i_auto = 1'b0; g[0].d_auto = 1'b0;
    g[1].i_auto = 1'b0; g[1].d_auto = 1'b0;
    repeat (20) @(negedge clk);

    // reset in the middle of a D grant, then a stray mem_ready_i
    g[1].mem_lat = 20; g[1].d_auto = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (g[1].bus.grant_o == 2'b10) got = 1'b1;
    end
    chk(1, "t6_granted", got, 1'b1);
    g[1].d_auto = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk(1, "t6_async_mem_valid", g[1].bus.mem_valid_o, 1'b0);
    chk(1, "t6_async_grant", g[1].bus.grant_o, 2'b00);
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    g[1].mem_en = 1'b0;
    g[1].inj_req++;
    got = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (g[1].bus.mem_ready_i) got = 1'b1;
      chk(1, "t6_no_ready", {g[1].bus.i_ready_o, g[1].bus.d_ready_o}, 2'b00);
    end
    chk(1, "t6_stray_ready_seen", got, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
